aes_composite_dec: RTL

//  AES-128 decryption core, one inverse round per clock, composite-field (GF((2^4)^2)) inverse S-box.

---
 rtl/aes_composite_dec.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_composite_dec.sv
// AES-128 decryption core: one inverse round per clock, forward key pass to reach K10.
// S-box inversion is reduced to GF(2^4) via the tower-field norm x^17 of GF((2^4)^2).
module aes_composite_dec #(
  parameter bit BUBBLE = 1'b1
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         EN,
  input  logic [127:0] Kin,
  input  logic         Krdy,
  output logic         Kvld,
  input  logic [127:0] Din,
  input  logic         Drdy,
  output logic [127:0] Dout,
  output logic         Dvld,
  output logic         BSY
);
  // Storage polarity of dat/rkey/dkey; ports always carry true polarity.
  localparam logic [127:0] MASK = BUBBLE ? {128{1'b1}} : 128'd0;

  typedef enum logic [1:0] {IDLE, KEXP, DEC} state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^-1 = x^16 * (x^17)^14; x^17 lies in the GF(2^4) subfield, where y^-1 = y^14.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x16, nrm, n2, n4, n8;
    x16 = gf_mul(x, x);
    x16 = gf_mul(x16, x16);
    x16 = gf_mul(x16, x16);
    x16 = gf_mul(x16, x16);
    nrm = gf_mul(x16, x);
    n2  = gf_mul(nrm, nrm);
    n4  = gf_mul(n2, n2);
    n8  = gf_mul(n4, n4);
    return gf_mul(gf_mul(gf_mul(n2, n4), n8), x16);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot_word(k[31:0], rc);
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot_word(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

  // Byte i sits at [127-8i -: 8]; state row r, column c is byte 4c+r.
  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   b;
    o = '0;
    coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = '0;
        for (int j = 0; j < 4; j++) b = b ^ gf_mul(coef[(j + 4 - r) % 4], a[j]);
        o[127 - 8*(4*c + r) -: 8] = b;
      end
    end
    return o;
  endfunction

  state_t         state, state_d;
  logic [3:0]     rnd, rnd_d;
  logic [7:0]     rcon;
  logic           key_ok;
  logic [127:0]   dat_q, rkey_q, dkey_q;
  logic           start_k, start_d, k_step, d_step, last;

  logic [127:0] dat, rkey, dkey, rkey_fwd, rkey_inv, t, dat_next;
  logic [7:0]   rcon_fwd, rcon_inv;

  assign dat      = dat_q ^ MASK;
  assign rkey     = rkey_q ^ MASK;
  assign dkey     = dkey_q ^ MASK;
  assign last     = (rnd == 4'd10);
  assign rkey_fwd = key_exp(rkey, rcon);
  assign rkey_inv = inv_key_exp(rkey, rcon);
  assign t        = inv_sub_shift(dat) ^ rkey_inv;
  assign dat_next = last ? t : inv_mix_columns(t);
  assign rcon_fwd = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
  assign rcon_inv = rcon[0] ? (((rcon ^ 8'h1B) >> 1) | 8'h80) : (rcon >> 1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state;
    rnd_d   = rnd;
    start_k = 1'b0;
    start_d = 1'b0;
    k_step  = 1'b0;
    d_step  = 1'b0;
    case (state)
      IDLE: begin
        if (Krdy) begin
          state_d = KEXP;
          rnd_d   = 4'd1;
          start_k = 1'b1;
        end else if (Drdy && key_ok) begin
          state_d = DEC;
          rnd_d   = 4'd1;
          start_d = 1'b1;
        end
      end
      KEXP, DEC: begin
        k_step = (state == KEXP);
        d_step = (state == DEC);
        if (last) state_d = IDLE;
        else      rnd_d   = rnd + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
    end else if (EN) begin
      state <= state_d;
      rnd   <= rnd_d;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rcon   <= 8'h01;
      key_ok <= 1'b0;
      dat_q  <= MASK;
      rkey_q <= MASK;
      dkey_q <= MASK;
      Dout   <= '0;
      Kvld   <= 1'b0;
      Dvld   <= 1'b0;
      BSY    <= 1'b0;
    end else if (EN) begin
      Kvld <= k_step & last;
      Dvld <= d_step & last;
      BSY  <= (state_d != IDLE);
      if (start_k) begin
        rkey_q <= Kin ^ MASK;
        rcon   <= 8'h01;
        key_ok <= 1'b0;
      end else if (start_d) begin
        dat_q  <= Din ^ dkey ^ MASK;
        rkey_q <= dkey_q;
        rcon   <= 8'h36;
      end else if (k_step) begin
        rkey_q <= rkey_fwd ^ MASK;
        rcon   <= rcon_fwd;
        if (last) begin
          dkey_q <= rkey_fwd ^ MASK;
          key_ok <= 1'b1;
        end
      end else if (d_step) begin
        dat_q  <= dat_next ^ MASK;
        rkey_q <= rkey_inv ^ MASK;
        rcon   <= rcon_inv;
        if (last) Dout <= dat_next;
      end
    end
  end
endmodule
